// File: rtl/painterengine_gpu_dma_reader.sv
// rtl/painterengine_gpu_dma_reader.sv - AXI4 read master of the GPU DMA streaming words to one of 4 consumers
// Optional handshake watchdog: define PAINTERENGINE_GPU_READER_TIMEOUT_EN.
module painterengine_gpu_dma_reader #(
  parameter int PARAM_MAX_BURST = 256,
  parameter int PARAM_TIMEOUT   = 256
) (
  input  logic         i_wire_clock,
  input  logic         i_wire_reset,
  input  logic [3:0]   i_wire_router,
  input  logic [127:0] i_wire_address,
  input  logic [127:0] i_wire_length,
  output logic [127:0] o_wire_data,
  output logic [3:0]   o_wire_data_valid,
  input  logic [3:0]   i_wire_data_next,
  output logic         o_wire_done,
  output logic         o_wire_error,
  output logic [2:0]   o_wire_error_type,
  output logic         o_wire_M_AXI_ARID,
  output logic [31:0]  o_wire_M_AXI_ARADDR,
  output logic [7:0]   o_wire_M_AXI_ARLEN,
  output logic [2:0]   o_wire_M_AXI_ARSIZE,
  output logic [1:0]   o_wire_M_AXI_ARBURST,
  output logic         o_wire_M_AXI_ARLOCK,
  output logic [3:0]   o_wire_M_AXI_ARCACHE,
  output logic [2:0]   o_wire_M_AXI_ARPROT,
  output logic [3:0]   o_wire_M_AXI_ARQOS,
  output logic         o_wire_M_AXI_ARVALID,
  input  logic         i_wire_M_AXI_ARREADY,
  input  logic         i_wire_M_AXI_RID,
  input  logic [31:0]  i_wire_M_AXI_RDATA,
  input  logic [1:0]   i_wire_M_AXI_RRESP,
  input  logic         i_wire_M_AXI_RLAST,
  input  logic         i_wire_M_AXI_RVALID,
  output logic         o_wire_M_AXI_RREADY
);
  localparam int LOG_BURST = $clog2(PARAM_MAX_BURST);

  typedef enum logic [4:0] {
    ST_ROUTING = 5'h01, ST_PARAM_CHECK = 5'h02, ST_CALC = 5'h03, ST_ADDR = 5'h04,
    ST_DATA = 5'h05, ST_DRAIN = 5'h06, ST_DONE = 5'h07,
    ST_ROUTING_ERR = 5'h10, ST_ALIGN_ERR = 5'h11, ST_LENGTH_ERR = 5'h12, ST_AR_TIMEOUT = 5'h13,
    ST_R_TIMEOUT = 5'h14, ST_RRESP_ERR = 5'h15, ST_RLAST_ERR = 5'h16
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [31:0] address, length, offset, araddr;
  logic [8:0]  beats, beat_cnt;
  logic [7:0]  arlen;
  logic        arvalid, hold_valid;
  logic [31:0] hold_data;

  logic [1:0]  route_idx;
  logic        route_onehot;
  logic [29:0] calc_word;
  logic [8:0]  to_bound, calc_beats;
  logic [31:0] remaining;
  logic        next_sel, consumer_hs, rready, r_hs, final_beat, wd_expired;
  logic        unused_rid;

  assign unused_rid = i_wire_M_AXI_RID;

  always_comb begin
    route_idx    = 2'd0;
    route_onehot = 1'b1;
    case (i_wire_router)
      4'b0001: route_idx = 2'd0;
      4'b0010: route_idx = 2'd1;
      4'b0100: route_idx = 2'd2;
      4'b1000: route_idx = 2'd3;
      default: route_onehot = 1'b0;
    endcase
  end

  // Burst length is capped both by the remaining words and by the distance to the next burst-aligned boundary.
  always_comb begin
    calc_word  = address[31:2] + offset[29:0];
    to_bound   = 9'(PARAM_MAX_BURST) - 9'(calc_word[LOG_BURST-1:0]);
    remaining  = length - offset;
    calc_beats = (remaining < {23'd0, to_bound}) ? remaining[8:0] : to_bound;
  end

  assign next_sel    = i_wire_data_next[idx];
  assign consumer_hs = hold_valid && next_sel;
  assign rready      = (state == ST_DATA) && (!hold_valid || next_sel);
  assign r_hs        = i_wire_M_AXI_RVALID && rready;
  assign final_beat  = (beat_cnt == beats - 9'd1);

`ifdef PAINTERENGINE_GPU_READER_TIMEOUT_EN
  logic [15:0] wd;
  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset || !((state == ST_ADDR && !i_wire_M_AXI_ARREADY) ||
                          (state == ST_DATA && !i_wire_M_AXI_RVALID)))
      wd <= 16'd0;
    else if (wd != 16'hFFFF)
      wd <= wd + 16'd1;
  end
  assign wd_expired = (wd >= 16'(PARAM_TIMEOUT - 1));
`else
  localparam int unused_timeout = PARAM_TIMEOUT;
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state      <= ST_ROUTING;
      idx        <= 2'd0;
      address    <= 32'd0;
      length     <= 32'd0;
      offset     <= 32'd0;
      beats      <= 9'd0;
      beat_cnt   <= 9'd0;
      araddr     <= 32'd0;
      arlen      <= 8'd0;
      arvalid    <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= 32'd0;
    end else begin
      if (consumer_hs) hold_valid <= 1'b0;
      case (state)
        ST_ROUTING: if (i_wire_router != 4'd0) begin
          if (route_onehot) begin
            idx     <= route_idx;
            address <= i_wire_address[{route_idx, 5'd0} +: 32];
            length  <= i_wire_length[{route_idx, 5'd0} +: 32];
            offset  <= 32'd0;
            state   <= ST_PARAM_CHECK;
          end else begin
            state <= ST_ROUTING_ERR;
          end
        end
        ST_PARAM_CHECK: begin
          if (address[1:0] != 2'd0)  state <= ST_ALIGN_ERR;
          else if (length == 32'd0)  state <= ST_LENGTH_ERR;
          else                       state <= ST_CALC;
        end
        ST_CALC: begin
          araddr  <= {calc_word, 2'b00};
          arlen   <= 8'(calc_beats - 9'd1);
          beats   <= calc_beats;
          arvalid <= 1'b1;
          state   <= ST_ADDR;
        end
        ST_ADDR: begin
          if (i_wire_M_AXI_ARREADY) begin
            arvalid  <= 1'b0;
            beat_cnt <= 9'd0;
            state    <= ST_DATA;
          end else if (wd_expired) begin
            arvalid <= 1'b0;
            state   <= ST_AR_TIMEOUT;
          end
        end
        ST_DATA: begin
          if (r_hs) begin
            if (i_wire_M_AXI_RRESP[1]) begin
              hold_valid <= 1'b0;
              state      <= ST_RRESP_ERR;
            end else if (i_wire_M_AXI_RLAST != final_beat) begin
              hold_valid <= 1'b0;
              state      <= ST_RLAST_ERR;
            end else begin
              hold_data  <= i_wire_M_AXI_RDATA;
              hold_valid <= 1'b1;
              beat_cnt   <= beat_cnt + 9'd1;
              if (final_beat) begin
                offset <= offset + 32'(beats);
                state  <= (offset + 32'(beats) >= length) ? ST_DRAIN : ST_CALC;
              end
            end
          end else if (!i_wire_M_AXI_RVALID && wd_expired) begin
            state <= ST_R_TIMEOUT;
          end
        end
        ST_DRAIN: if (!hold_valid) state <= ST_DONE;
        ST_DONE:  if (i_wire_router == 4'd0) state <= ST_ROUTING;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_wire_data       = 128'd0;
    o_wire_data_valid = 4'd0;
    if (hold_valid) begin
      o_wire_data[{idx, 5'd0} +: 32] = hold_data;
      o_wire_data_valid[idx]         = 1'b1;
    end
  end

  assign o_wire_done          = (state == ST_DONE);
  assign o_wire_error         = state[4];
  assign o_wire_error_type    = state[4] ? state[2:0] : 3'd0;
  assign o_wire_M_AXI_ARID    = 1'b0;
  assign o_wire_M_AXI_ARADDR  = araddr;
  assign o_wire_M_AXI_ARLEN   = arlen;
  assign o_wire_M_AXI_ARSIZE  = 3'b010;
  assign o_wire_M_AXI_ARBURST = 2'b01;
  assign o_wire_M_AXI_ARLOCK  = 1'b0;
  assign o_wire_M_AXI_ARCACHE = 4'b0010;
  assign o_wire_M_AXI_ARPROT  = 3'd0;
  assign o_wire_M_AXI_ARQOS   = 4'd0;
  assign o_wire_M_AXI_ARVALID = arvalid;
  assign o_wire_M_AXI_RREADY  = rready;
endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// tb/tb_painterengine_gpu_dma_reader.sv - scoreboard bench for the GPU DMA read master
module tb_painterengine_gpu_dma_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [3:0]   router;
  logic [127:0] address, length;
  logic [127:0] data;
  logic [3:0]   data_valid, next;
  logic         done, error;
  logic [2:0]   error_type;
  logic         arid, arlock, arvalid, arready;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize, arprot;
  logic [1:0]   arburst, rresp;
  logic [3:0]   arcache, arqos;
  logic         rid, rlast, rvalid, rready;
  logic [31:0]  rdata;

  painterengine_gpu_dma_reader dut (
    .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_router(router),
    .i_wire_address(address), .i_wire_length(length),
    .o_wire_data(data), .o_wire_data_valid(data_valid), .i_wire_data_next(next),
    .o_wire_done(done), .o_wire_error(error), .o_wire_error_type(error_type),
    .o_wire_M_AXI_ARID(arid), .o_wire_M_AXI_ARADDR(araddr), .o_wire_M_AXI_ARLEN(arlen),
    .o_wire_M_AXI_ARSIZE(arsize), .o_wire_M_AXI_ARBURST(arburst), .o_wire_M_AXI_ARLOCK(arlock),
    .o_wire_M_AXI_ARCACHE(arcache), .o_wire_M_AXI_ARPROT(arprot), .o_wire_M_AXI_ARQOS(arqos),
    .o_wire_M_AXI_ARVALID(arvalid), .i_wire_M_AXI_ARREADY(arready),
    .i_wire_M_AXI_RID(rid), .i_wire_M_AXI_RDATA(rdata), .i_wire_M_AXI_RRESP(rresp),
    .i_wire_M_AXI_RLAST(rlast), .i_wire_M_AXI_RVALID(rvalid), .o_wire_M_AXI_RREADY(rready)
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;
  ar_t         exp_ar[$];
  logic [31:0] exp_word[$];
  ar_t         bq[$];
  int errors = 0, checks = 0;
  int cur_ch = 0, xfer_beat = 0;
  int rresp_bad = -1, rlast_bad = -1;
  bit toggle = 0, ar_stall = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Slave memory model plus consumer; scoreboard pops happen here.
  initial begin : slave
    bit s_rst, s_ar, s_r, s_c, active;
    int blen, beat;
    logic [31:0] baddr, w;
    logic [127:0] lane_mask;
    ar_t e;
    active = 0; blen = 0; beat = 0; baddr = 0;
    rvalid = 0; rdata = 0; rlast = 0; rresp = 0; rid = 0; arready = 1; next = 4'hF;
    forever begin
      @(negedge clk);
      s_rst = rst;
      s_ar  = arvalid && arready;
      s_r   = rvalid && rready;
      s_c   = (data_valid & next) != 4'd0;
      if (!s_rst) begin
        if (s_ar) begin
          if (exp_ar.size() == 0) check("ar_extra", 1, 0);
          else begin
            e = exp_ar.pop_front();
            check("araddr", araddr, e.addr);
            check("arlen", arlen, e.len);
          end
          bq.push_back('{araddr, arlen});
        end
        if (s_c) begin
          if (exp_word.size() == 0) check("word_extra", 1, 0);
          else begin
            w = exp_word.pop_front();
            lane_mask = 128'hFFFFFFFF << (cur_ch * 32);
            check("word", data[cur_ch*32 +: 32], w);
            check("lanes", data & ~lane_mask, 0);
            check("valid_sel", data_valid, 4'b1 << cur_ch);
          end
        end
      end
      @(posedge clk); #1;
      if (s_rst) begin
        bq.delete();
        active = 0;
      end else if (s_r) begin
        beat++;
        xfer_beat++;
        if (beat == blen) active = 0;
      end
      if (!active && bq.size() > 0) begin
        e = bq.pop_front();
        baddr = e.addr; blen = int'(e.len) + 1; beat = 0; active = 1;
      end
      rvalid  = active;
      rdata   = mem(baddr + 32'(4 * beat));
      rlast   = active && ((beat == blen - 1) ^ (xfer_beat == rlast_bad));
      rresp   = (active && xfer_beat == rresp_bad) ? 2'b10 : 2'b00;
      next    = toggle ? ~next : 4'hF;
      arready = !ar_stall;
    end
  end

  task automatic start(input int ch, input logic [31:0] addr, input logic [31:0] len, input bit push);
    int off, b;
    logic [31:0] word;
    if (push) begin
      off = 0;
      while (off < int'(len)) begin
        word = (addr >> 2) + 32'(off);
        b = 256 - int'(word % 256);
        if (int'(len) - off < b) b = int'(len) - off;
        exp_ar.push_back('{word << 2, 8'(b - 1)});
        off += b;
      end
      for (int i = 0; i < int'(len); i++) exp_word.push_back(mem(addr + 32'(4 * i)));
    end
    for (int k = 0; k < 4; k++) begin
      address[k*32 +: 32] = $urandom;
      length[k*32 +: 32]  = $urandom;
    end
    address[ch*32 +: 32] = addr;
    length[ch*32 +: 32]  = len;
    cur_ch = ch;
    xfer_beat = 0;
    router = 4'b1 << ch;
  endtask

  task automatic do_reset();
    rst = 1; router = 0;
    tick(2);
    rst = 0;
    exp_ar.delete();
    exp_word.delete();
    tick(1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin tick(1); n++; end
    check(tag, done, 1);
  endtask

  task automatic wait_err(input string tag, input int budget, input logic [2:0] typ);
    int n = 0;
    while (!error && n < budget) begin tick(1); n++; end
    check(tag, error_type, typ);
  endtask

  task automatic finish_xfer(input string tag);
    check({tag, "_ar_left"}, exp_ar.size(), 0);
    check({tag, "_words_left"}, exp_word.size(), 0);
    router = 0;
    tick(2);
    check({tag, "_idle"}, done, 0);
  endtask

  initial begin : main
    int n;
    rst = 1; router = 0; address = 0; length = 0;
    tick(3);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_dvalid", data_valid, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_data", data, 0);
    rst = 0;
    tick(1);

    start(1, 32'h1000, 4, 1);
    tick(2);
    check("lat_pre", arvalid, 0);
    tick(1);
    check("lat_ar", arvalid, 1);
    wait_done("t1_done", 200);
    tick(5);
    check("t1_hold_done", done, 1);
    finish_xfer("t1");

    start(0, 32'h13F8, 10, 1);
    wait_done("t2_done", 300);
    finish_xfer("t2");

    toggle = 1;
    start(2, 32'h2000, 300, 1);
    wait_done("t3_done", 3000);
    finish_xfer("t3");
    toggle = 0;

    start(3, 32'h03FC, 3, 1);
    wait_done("t3b_done", 300);
    finish_xfer("t3b");

    do_reset();
    router = 4'b0011;
    tick(1);
    check("route_err", error, 1);
    check("route_err_type", error_type, 0);
    do_reset();
    start(1, 32'h1002, 4, 0);
    tick(2);
    check("align_err_type", error_type, 1);
    do_reset();
    start(2, 32'h1000, 0, 0);
    tick(2);
    check("len_err_type", error_type, 2);
    check("len_err", error, 1);

    do_reset();
    rresp_bad = 2;
    start(1, 32'h1000, 4, 0);
    exp_ar.push_back('{32'h1000, 8'd3});
    exp_word.push_back(mem(32'h1000));
    exp_word.push_back(mem(32'h1004));
    wait_err("rresp_type", 100, 3'd5);
    tick(3);
    check("rresp_ar_left", exp_ar.size(), 0);
    check("rresp_words_left", exp_word.size(), 0);
    rresp_bad = -1;

    do_reset();
    rlast_bad = 1;
    start(0, 32'h1000, 4, 0);
    exp_ar.push_back('{32'h1000, 8'd3});
    exp_word.push_back(mem(32'h1000));
    wait_err("rlast_type", 100, 3'd6);
    tick(3);
    check("rlast_words_left", exp_word.size(), 0);
    rlast_bad = -1;

    do_reset();
    toggle = 1;
    start(0, 32'h3000, 20, 1);
    n = 0;
    while (data_valid == 0 && n < 50) begin tick(1); n++; end
    check("mid_dv_seen", data_valid != 0, 1);
    rst = 1; router = 0;
    tick(1);
    check("mid_rst_data", data, 0);
    check("mid_rst_dvalid", data_valid, 0);
    check("mid_rst_arvalid", arvalid, 0);
    check("mid_rst_rready", rready, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    toggle = 0;
    do_reset();

`ifdef PAINTERENGINE_GPU_READER_TIMEOUT_EN
    ar_stall = 1;
    start(0, 32'h1000, 4, 0);
    tick(3);
    n = 0;
    while (!error && n < 400) begin tick(1); n++; end
    check("ar_to_type", error_type, 3);
    check("ar_to_cycles", (n >= 255 && n <= 257), 1);
    ar_stall = 0;
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
